// File: rtl/universal_shift_reg.sv
// Universal shift register: shift/rotate left and right, parallel load, clear,
// and a counted burst-shift engine with busy/done status.
// Optional build macro: USR_PARITY_EN adds output `par` (XOR reduction of q).
module universal_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pi,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_ROR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   q_q;
    logic               sout_q;
    logic               busy_q;
    logic               done_q;
    logic [2:0]         op_q;
    logic [LEN_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   q_d;
    logic               sout_d;
    logic [2:0]         step_op_c;
    logic [LEN_W-1:0]   len_c;
    logic               is_shift_c;

    // Burst length clamp and shift-op classification for the start request
    always_comb begin
        len_c      = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
        is_shift_c = (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
        step_op_c  = (state_q == ST_BURST) ? op_q : op;
    end

    // Result of one step of the selected op on the current register contents
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        case (step_op_c)
            OP_SHR: begin
                q_d    = {sin_r, q_q[WIDTH-1:1]};
                sout_d = q_q[0];
            end
            OP_SHL: begin
                q_d    = {q_q[WIDTH-2:0], sin_l};
                sout_d = q_q[WIDTH-1];
            end
            OP_ROR: begin
                q_d    = {q_q[0], q_q[WIDTH-1:1]};
                sout_d = q_q[0];
            end
            OP_ROL: begin
                q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                sout_d = q_q[WIDTH-1];
            end
            OP_LOAD:  q_d = pi;
            OP_CLEAR: q_d = '0;
            default: begin
                q_d    = q_q;
                sout_d = sout_q;
            end
        endcase
    end

    // Control FSM and datapath registers; priority reset > burst > start > en
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_BURST: begin
                    q_q    <= q_d;
                    sout_q <= sout_d;
                    cnt_q  <= cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift_c && (len_c != '0)) begin
                            q_q    <= q_d;
                            sout_q <= sout_d;
                            op_q   <= op;
                            cnt_q  <= len_c - LEN_ONE;
                            if (len_c == LEN_ONE) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_BURST;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            // Degenerate burst: nothing moves, just acknowledge
                            done_q <= 1'b1;
                        end
                    end else if (en) begin
                        q_q    <= q_d;
                        sout_q <= sout_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef USR_PARITY_EN
    // Parity of the registered contents
    assign par = ^q_q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8): the driver pushes the
// hand-computed post-edge state for every edge; a monitor pops and compares.
module tb_universal_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;

    localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011,
                           ROL = 3'b100, LOAD = 3'b101, CLR = 3'b110, HOLD7 = 3'b111;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             sout;
        logic             busy;
        logic             done;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pi;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;
`ifdef USR_PARITY_EN
    logic             par;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    universal_shift_reg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pi        (pi),
        .start     (start),
        .burst_len (burst_len),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
`ifdef USR_PARITY_EN
        ,
        .par       (par)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per edge, sampled 1 time unit after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q) begin
                failures++;
                $display("FAIL %s q: got %h expected %h", e.tag, q, e.q);
            end
            checks++;
            if (sout !== e.sout) begin
                failures++;
                $display("FAIL %s sout: got %b expected %b", e.tag, sout, e.sout);
            end
            checks++;
            if (busy !== e.busy) begin
                failures++;
                $display("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
            end
            checks++;
            if (done !== e.done) begin
                failures++;
                $display("FAIL %s done: got %b expected %b", e.tag, done, e.done);
            end
`ifdef USR_PARITY_EN
            checks++;
            if (par !== (^e.q)) begin
                failures++;
                $display("FAIL %s par: got %b expected %b", e.tag, par, ^e.q);
            end
`endif
        end
    end

    // Drive one edge worth of inputs and queue the expected post-edge state
    task automatic go(input logic r, input logic e, input logic [2:0] o,
                      input logic sr, input logic sl, input logic [WIDTH-1:0] p,
                      input logic st, input logic [LEN_W-1:0] bl,
                      input logic [WIDTH-1:0] eq, input logic es, input logic eb,
                      input logic ed, input string tag);
        exp_t x;
        rst = r; en = e; op = o; sin_r = sr; sin_l = sl; pi = p;
        start = st; burst_len = bl;
        x.q = eq; x.sout = es; x.busy = eb; x.done = ed; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    logic [WIDTH-1:0] rol_q [7];

    initial begin
        rol_q = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        rst = 1'b0; en = 1'b0; op = HOLD; sin_r = 1'b0; sin_l = 1'b0;
        pi = '0; start = 1'b0; burst_len = '0;
        #2;

        // Reset wins over a concurrent load
        go(0, 1, LOAD, 0, 0, 8'hFF, 0, 0,   8'h00, 0, 0, 0, "reset");
        go(1, 1, LOAD, 0, 0, 8'hA5, 0, 0,   8'hA5, 0, 0, 0, "load_a5");
        go(1, 1, SHR,  1, 0, 8'h00, 0, 0,   8'hD2, 1, 0, 0, "shr");
        go(1, 1, SHL,  0, 0, 8'h00, 0, 0,   8'hA4, 1, 0, 0, "shl");
        go(1, 0, SHL,  0, 1, 8'h00, 0, 0,   8'hA4, 1, 0, 0, "en_low");
        go(1, 1, HOLD7,1, 1, 8'hFF, 0, 0,   8'hA4, 1, 0, 0, "hold7");
        go(1, 1, HOLD, 1, 1, 8'hFF, 0, 0,   8'hA4, 1, 0, 0, "hold0");

        // Rotate wrap-around
        go(1, 1, LOAD, 0, 0, 8'h81, 0, 0,   8'h81, 1, 0, 0, "load_81");
        go(1, 1, ROL,  0, 0, 8'h00, 0, 0,   8'h03, 1, 0, 0, "rol1");
        for (int i = 0; i < 7; i++)
            go(1, 1, ROL, 0, 0, 8'h00, 0, 0, rol_q[i], (i == 6), 0, 0, "rol_more");
        go(1, 1, ROR,  0, 0, 8'h00, 0, 0,   8'hC0, 1, 0, 0, "ror");
        go(1, 1, CLR,  0, 0, 8'hFF, 0, 0,   8'h00, 1, 0, 0, "clear");

        // Burst SHL x4 with en/op/start noise while busy
        go(1, 1, LOAD, 0, 0, 8'h0F, 0, 0,   8'h0F, 1, 0, 0, "load_0f");
        go(1, 0, SHL,  0, 0, 8'h00, 1, 4,   8'h1E, 0, 1, 0, "burst_e0");
        go(1, 1, LOAD, 0, 0, 8'hFF, 1, 2,   8'h3C, 0, 1, 0, "burst_e1");
        go(1, 1, CLR,  0, 0, 8'hFF, 0, 0,   8'h78, 0, 1, 0, "burst_e2");
        go(1, 1, LOAD, 0, 0, 8'hFF, 0, 0,   8'hF0, 0, 0, 1, "burst_e3");
        // Start accepted in the done cycle; L=1 burst finishes immediately
        go(1, 0, SHR,  0, 0, 8'h00, 1, 1,   8'h78, 0, 0, 1, "b2b_len1");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h78, 0, 0, 0, "after_len1");

        // Oversized length clamps to WIDTH: 8 rotates return to start
        go(1, 0, ROR,  0, 0, 8'h00, 1, 15,  8'h3C, 0, 1, 0, "clamp1");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h1E, 0, 1, 0, "clamp2");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h0F, 0, 1, 0, "clamp3");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h87, 1, 1, 0, "clamp4");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'hC3, 1, 1, 0, "clamp5");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'hE1, 1, 1, 0, "clamp6");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'hF0, 1, 1, 0, "clamp7");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h78, 0, 0, 1, "clamp8");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h78, 0, 0, 0, "clamp_idle");

        // Reset at the third burst edge aborts without done
        go(1, 0, ROR,  0, 0, 8'h00, 1, 8,   8'h3C, 0, 1, 0, "abort_e0");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h1E, 0, 1, 0, "abort_e1");
        go(0, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h00, 0, 0, 0, "abort_rst");
        for (int i = 0; i < 4; i++)
            go(1, 0, HOLD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, "abort_quiet");

        // Degenerate starts: zero length, non-shift op
        go(1, 1, LOAD, 0, 0, 8'h5A, 0, 0,   8'h5A, 0, 0, 0, "load_5a");
        go(1, 1, SHR,  1, 1, 8'h00, 1, 0,   8'h5A, 0, 0, 1, "start_len0");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h5A, 0, 0, 0, "len0_after");
        go(1, 1, LOAD, 0, 0, 8'hFF, 1, 3,   8'h5A, 0, 0, 1, "start_load");
        go(1, 0, HOLD, 0, 0, 8'h00, 0, 0,   8'h5A, 0, 0, 0, "load_after");

        // Parity patterns (par compared when enabled)
        go(1, 1, LOAD, 0, 0, 8'h07, 0, 0,   8'h07, 0, 0, 0, "par_07");
        go(1, 1, LOAD, 0, 0, 8'h03, 0, 0,   8'h03, 0, 0, 0, "par_03");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
